gpio_event_core: RTL
====================

GPIO_EVENT_CORE -- requirements
Module: gpio_event_core

Interface
REQ-001 Parameter NUM_PINS, default 16, number of GPIO pins (legal range 1..32).
REQ-002 Parameter GPIO_OUT_CAPABLE, default 16'hFF00 (NUM_PINS bits), pins permitted to drive.
REQ-003 Parameter DEBOUNCE_BITS, default 8, width of the per-pin debounce counter and the threshold register.
REQ-004 Parameter DEBOUNCE_RESET, default 4, reset value of the debounce threshold.
REQ-005 Port list (name, direction, width, meaning), clock and reset first:
 clock  in  1  sole clock.
 reset_n  in  1  asynchronous, active-low reset.
 gpio_in  in  NUM_PINS  raw pad inputs, asynchronous to clock.
 gpio_out  out  NUM_PINS  output data, to pad tristate at top level.
 gpio_oe  out  NUM_PINS  output enable, 1 = drive.
 cfg_data_mwrite  in  32  write data.
 cfg_data_mread  out  32  read data.
 cfg_addr  in  8  register address.
 cfg_mread_en  in  1  read request.
 cfg_mwrite_en  in  1  write request.
 cfg_sack  out  1  slave acknowledge.
 error_flag  out  1  error_cfg bit.
 event_irq  out  1  OR of all event status bits.
REQ-006 The block SHALL have one clock domain; reset_n SHALL be asynchronous assert, active-low, with synchronous deassert provided externally.

Function
REQ-007 Register map SHALL be:
 0x00 R/W error (bit0 = cfg error);
 0x01 RO 0;
 0x02 RO GPIO_OUT_CAPABLE;
 0x03 R/W direction (1 = output);
 0x04 W output data / R pin state;
 0x05 R/W debounce threshold;
 0x06 R/W rise enable;
 0x07 R/W fall enable;
 0x08 R/W1C event status;
 0x09 RO {8'h02 version, 16'd0, NUM_PINS[7:0]}.
REQ-008 A request SHALL be acted on once, on the first cycle cfg_mread_en|cfg_mwrite_en is seen high after being low.
REQ-009 cfg_sack SHALL rise one cycle after that cycle, stay high while the enable is held, and fall one cycle after the enable drops.
REQ-010 cfg_data_mread SHALL be valid in the first cycle cfg_sack is high and SHALL hold until the next request.
REQ-011 Write readback SHALL return the value stored after masking; a read SHALL return register contents, with bits above NUM_PINS reading 0.
REQ-012 The following SHALL set error_cfg and return 0 with no other state change: writes to 0x01/0x02/0x09, any address >0x09, or both enables high together.
REQ-013 gpio_oe SHALL equal direction & GPIO_OUT_CAPABLE; direction bits outside GPIO_OUT_CAPABLE SHALL be stored as 0.
REQ-014 gpio_out SHALL equal out_reg & GPIO_OUT_CAPABLE; output pins SHALL change one cycle after the write is acted on.
REQ-015 Every pin SHALL pass through a 2-flop synchronizer, then a debounce counter.
REQ-016 Debounce: when sync equals the debounced value, the counter SHALL clear; otherwise it SHALL increment. When the counter equals threshold T, debounced SHALL take the sync value and the counter SHALL clear.
REQ-017 With threshold T, debounced SHALL update on the (T+1)th consecutive differing cycle; T=0 gives 1 cycle. Pulses of ≤T sync cycles SHALL be rejected.
REQ-018 Reading 0x04 SHALL return the debounced state for input pins and out_reg for output pins.
REQ-019 An event status bit SHALL set on a debounced 0->1 transition with rise enabled, or 1->0 with fall enabled, only while the pin is input-direction.
REQ-020 W1C: writing 1 to an event status bit SHALL clear it; a set and a clear in the same cycle SHALL leave the bit set.
REQ-021 event_irq SHALL be a registered OR of event status, asserting the cycle after a bit sets.
REQ-022 A threshold change SHALL take effect on the next cycle; in-progress counts SHALL be compared against the new value.

Reset
REQ-023 On reset_n low, all registers SHALL clear to 0 (outputs, sack, mread, error, direction, out_reg, enables, status, synchronizers, counters, debounced state), except threshold, which SHALL load DEBOUNCE_RESET. A request in progress SHALL be dropped, not acked.

Structure
REQ-024 Shared package gpio_pkg SHALL hold register address constants, version 8'h02, and the error bit index.
REQ-025 Sub-module gpio_debounce (one pin: synchronizer, counter, debounced flop, rise/fall strobes) SHALL be instantiated NUM_PINS times by generate.

Verification
REQ-026 Write 0x03=0xFFFF, read 0x03 -> 0xFF00; gpio_oe=0xFF00.
REQ-027 T=4, pin0 pulse of 3 cycles -> no change; 10-cycle high -> debounced rises 7 cycles after pad edge; with rise_en[0] set, status=0x0001 and event_irq=1.
REQ-028 Write 0x08=0x0001 coincident with a new pin0 rise -> status stays 0x0001; a later clear -> 0, event_irq=0.
REQ-029 Write 0x01, or read 0x0A, or both enables high -> error_flag=1, mread=0; write 0x00=0 -> error_flag=0.
REQ-030 Enable held 5 cycles -> exactly one action; sack high cycles 2-6.
REQ-031 Assert reset_n low mid-request -> sack=0 and threshold reads 4 after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO event core: register map, version, error bit.
package gpio_pkg;

  localparam logic [7:0] ADDR_ERROR   = 8'h00;
  localparam logic [7:0] ADDR_ZERO    = 8'h01;
  localparam logic [7:0] ADDR_CAP     = 8'h02;
  localparam logic [7:0] ADDR_DIR     = 8'h03;
  localparam logic [7:0] ADDR_DATA    = 8'h04;
  localparam logic [7:0] ADDR_THRESH  = 8'h05;
  localparam logic [7:0] ADDR_RISE_EN = 8'h06;
  localparam logic [7:0] ADDR_FALL_EN = 8'h07;
  localparam logic [7:0] ADDR_STATUS  = 8'h08;
  localparam logic [7:0] ADDR_VERSION = 8'h09;

  localparam logic [7:0] VERSION = 8'h02;
  localparam int         ERR_BIT = 0;

  // Addresses that may be read but never written.
  function automatic logic is_read_only(input logic [7:0] addr);
    return (addr == ADDR_ZERO) || (addr == ADDR_CAP) || (addr == ADDR_VERSION);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin: 2-flop synchronizer, debounce counter, debounced flop and edge strobes.
module gpio_debounce #(
  parameter int CNT_BITS = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                pin_i,
  input  logic [CNT_BITS-1:0] threshold_i,
  output logic                debounced_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic                sync1_q, sync2_q, deb_q, deb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                differ, hit;

  // The debounced value follows sync only after T+1 consecutive differing cycles.
  always_comb begin
    differ = (sync2_q != deb_q);
    hit    = differ && (cnt_q == threshold_i);
    cnt_d  = (differ && !hit) ? cnt_q + 1'b1 : '0;
    deb_d  = hit ? sync2_q : deb_q;
  end

  // Synchronizer, counter and debounced state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign debounced_o = deb_q;
  // Strobes coincide with the edge that updates deb_q.
  assign rise_o      = hit &  sync2_q;
  assign fall_o      = hit & ~sync2_q;

endmodule

// File: rtl/gpio_event_core.sv
// GPIO block: config register file, per-pin debounce and edge event status/IRQ.
module gpio_event_core
  import gpio_pkg::*;
#(
  parameter int                  NUM_PINS         = 16,
  parameter logic [NUM_PINS-1:0] GPIO_OUT_CAPABLE = 16'hFF00,
  parameter int                  DEBOUNCE_BITS    = 8,
  parameter int                  DEBOUNCE_RESET   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  input  logic [31:0]         cfg_data_mwrite,
  output logic [31:0]         cfg_data_mread,
  input  logic [7:0]          cfg_addr,
  input  logic                cfg_mread_en,
  input  logic                cfg_mwrite_en,
  output logic                cfg_sack,
  output logic                error_flag,
  output logic                event_irq
);

  localparam logic [DEBOUNCE_BITS-1:0] THRESH_RST = DEBOUNCE_BITS'(DEBOUNCE_RESET);

  logic                     sack_q, error_q, error_d, irq_q;
  logic [31:0]              mread_q, mread_d;
  logic [NUM_PINS-1:0]      dir_q, dir_d, out_q, out_d, rise_en_q, rise_en_d;
  logic [NUM_PINS-1:0]      fall_en_q, fall_en_d, status_q, status_d;
  logic [DEBOUNCE_BITS-1:0] thresh_q, thresh_d;
  logic [NUM_PINS-1:0]      deb, rise_vec, fall_vec, status_set, w1c_mask, wdata_pins;
  logic                     req, act, cfg_error;
  logic                     unused_wdata;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    gpio_debounce #(.CNT_BITS(DEBOUNCE_BITS)) u_deb (
      .clock       (clock),
      .reset_n     (reset_n),
      .pin_i       (gpio_in[gi]),
      .threshold_i (thresh_q),
      .debounced_o (deb[gi]),
      .rise_o      (rise_vec[gi]),
      .fall_o      (fall_vec[gi])
    );
  end

  // A request is acted on only in the cycle the enable is first seen high.
  assign req          = cfg_mread_en | cfg_mwrite_en;
  assign act          = req & ~sack_q;
  assign wdata_pins   = cfg_data_mwrite[NUM_PINS-1:0];
  assign unused_wdata = ^cfg_data_mwrite;
  assign cfg_error    = (cfg_mread_en & cfg_mwrite_en) | (cfg_addr > ADDR_VERSION) |
                        (cfg_mwrite_en & is_read_only(cfg_addr));
  // Events only count on input-direction pins.
  assign status_set   = ~dir_q & ((rise_vec & rise_en_q) | (fall_vec & fall_en_q));

  // Register file decode: next state and the read/readback data.
  always_comb begin
    dir_d     = dir_q;
    out_d     = out_q;
    thresh_d  = thresh_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    error_d   = error_q;
    mread_d   = mread_q;
    w1c_mask  = '0;
    if (act) begin
      if (cfg_error) begin
        error_d = 1'b1;
        mread_d = '0;
      end else if (cfg_mwrite_en) begin
        case (cfg_addr)
          ADDR_ERROR:   begin error_d   = cfg_data_mwrite[ERR_BIT]; mread_d = 32'(error_d); end
          ADDR_DIR:     begin dir_d     = wdata_pins & GPIO_OUT_CAPABLE; mread_d = 32'(dir_d); end
          ADDR_DATA:    begin out_d     = wdata_pins; mread_d = 32'(out_d); end
          ADDR_THRESH:  begin thresh_d  = cfg_data_mwrite[DEBOUNCE_BITS-1:0]; mread_d = 32'(thresh_d); end
          ADDR_RISE_EN: begin rise_en_d = wdata_pins; mread_d = 32'(rise_en_d); end
          ADDR_FALL_EN: begin fall_en_d = wdata_pins; mread_d = 32'(fall_en_d); end
          ADDR_STATUS:  begin
            w1c_mask = wdata_pins;
            mread_d  = 32'((status_q & ~wdata_pins) | status_set);
          end
          default:      mread_d = '0;
        endcase
      end else begin
        case (cfg_addr)
          ADDR_ERROR:   mread_d = 32'(error_q);
          ADDR_CAP:     mread_d = 32'(GPIO_OUT_CAPABLE);
          ADDR_DIR:     mread_d = 32'(dir_q);
          ADDR_DATA:    mread_d = 32'((deb & ~dir_q) | (out_q & dir_q));
          ADDR_THRESH:  mread_d = 32'(thresh_q);
          ADDR_RISE_EN: mread_d = 32'(rise_en_q);
          ADDR_FALL_EN: mread_d = 32'(fall_en_q);
          ADDR_STATUS:  mread_d = 32'(status_q);
          ADDR_VERSION: mread_d = {VERSION, 16'd0, 8'(NUM_PINS)};
          default:      mread_d = '0;
        endcase
      end
    end
    // A new event wins over a simultaneous clear.
    status_d = (status_q & ~w1c_mask) | status_set;
  end

  // Register state; threshold is the only non-zero reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sack_q    <= 1'b0;
      mread_q   <= '0;
      error_q   <= 1'b0;
      dir_q     <= '0;
      out_q     <= '0;
      thresh_q  <= THRESH_RST;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      sack_q    <= req;
      mread_q   <= mread_d;
      error_q   <= error_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      thresh_q  <= thresh_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= |status_q;
    end
  end

  assign gpio_oe        = dir_q & GPIO_OUT_CAPABLE;
  assign gpio_out       = out_q & GPIO_OUT_CAPABLE;
  assign cfg_sack       = sack_q;
  assign cfg_data_mread = mread_q;
  assign error_flag     = error_q;
  assign event_irq      = irq_q;

endmodule
